// File: rtl/corefifo_wr_stage.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | corefifo_wr_stage: two-entry skid front-end driving the CoreFIFO write   |
// | port with full/almost-full throttling.                       Rev 1.0     |
// +--------------------------------------------------------------------------+
module corefifo_wr_stage #(
  parameter int WWIDTH    = 10,
  parameter int WRITE_LOW = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_wclk_top,
  input  logic [WWIDTH-1:0]    din,
  input  logic                 din_vld,
  output logic                 din_rdy,
  output logic [WWIDTH-1:0]    fifo_din,
  output logic                 fifo_wr_en,
  input  logic                 fifo_full,
  input  logic                 fifo_afull,
  output logic [CNT_WIDTH-1:0] wr_count,
  output logic                 idle
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [WWIDTH-1:0]   slot0_q, slot0_d;
  logic [WWIDTH-1:0]   slot1_q, slot1_d;
  logic                issue_r_q;
  logic [CNT_WIDTH-1:0] wr_count_q;
  logic                idle_q;
  logic                w_accept;
  logic                w_issue;

  assign din_rdy  = (state_q != TWO);
  assign w_accept = din_vld & din_rdy;
  // The FIFO flags lag one write, so a back-to-back write under afull could overflow.
  assign w_issue  = (state_q != EMPTY) & ~fifo_full & ~(fifo_afull & issue_r_q);

  assign fifo_din   = slot0_q;
  assign fifo_wr_en = (WRITE_LOW != 0) ? ~w_issue : w_issue;
  assign wr_count   = wr_count_q;
  assign idle       = idle_q;

  always_comb begin
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    unique case (state_q)
      EMPTY: begin
        if (w_accept) begin
          state_d = ONE;
          slot0_d = din;
        end
      end
      ONE: begin
        if (w_accept && !w_issue) begin
          state_d = TWO;
          slot1_d = din;
        end else if (!w_accept && w_issue) begin
          state_d = EMPTY;
        end else if (w_accept && w_issue) begin
          slot0_d = din;
        end
      end
      TWO: begin
        if (w_issue) begin
          state_d = ONE;
          slot0_d = slot1_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset_wclk_top) begin
    if (reset_wclk_top) begin
      state_q    <= EMPTY;
      slot0_q    <= '0;
      slot1_q    <= '0;
      issue_r_q  <= 1'b0;
      wr_count_q <= '0;
      idle_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      issue_r_q  <= w_issue;
      idle_q     <= (state_d == EMPTY);
      if (w_issue) begin
        wr_count_q <= wr_count_q + C_CNT_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/corefifo_wr_stage.md
Name: corefifo_wr_stage

Overview:
- Write-side staging front-end for the CoreFIFO instance, at the opposite end from the FWFT read wrapper.
- Upstream provides a valid/ready stream. The block holds up to two words in a skid buffer and drives the FIFO write port.
- It throttles on fifo_full/fifo_afull so that no write is ever issued into a full FIFO, even though the FIFO's flags lag by one cycle.
- It also provides a running write count and an idle flag for the arbiter.

Parameters:
- WWIDTH, 10, data width in bits of din and fifo_din.
- WRITE_LOW, 1, polarity of fifo_wr_en: 1 = active-low, 0 = active-high.
- CNT_WIDTH, 16, width of the wr_count counter.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset_wclk_top  in  1  asynchronous, active-high reset.
- din  in  WWIDTH  upstream data.
- din_vld  in  1  upstream valid (active-high).
- din_rdy  out  1  upstream ready (active-high).
- fifo_din  out  WWIDTH  data to the FIFO write port.
- fifo_wr_en  out  1  FIFO write enable; polarity set by WRITE_LOW.
- fifo_full  in  1  FIFO full flag (active-high).
- fifo_afull  in  1  FIFO almost-full flag (active-high); asserted when at most one free slot remains.
- wr_count  out  CNT_WIDTH  number of words written into the FIFO; wraps.
- idle  out  1  high when the skid buffer is empty.

Behaviour:
- Storage:
  - slot0 is the head; fifo_din = slot0 at all times.
  - slot1 is the skid entry.
  - State is held in a registered occupancy: EMPTY(0), ONE(1), TWO(2).
- Definitions:
  - accept = din_vld & din_rdy.
  - din_rdy = (state != TWO). It depends only on registered state; there is no combinational path from din_vld.
  - issue = (state != EMPTY) & !fifo_full & !(fifo_afull & issue_r), where issue_r is issue registered one cycle.
  - The issue_r term blocks a second consecutive write while afull is asserted, because the FIFO flags have not yet reflected the previous write.
  - fifo_wr_en = issue when WRITE_LOW=0, and ~issue when WRITE_LOW=1. It is combinational from registers plus the fifo_full/fifo_afull inputs.
- State transitions:
  - EMPTY: accept → ONE, din loaded into slot0.
  - ONE, accept & !issue → TWO, din loaded into slot1.
  - ONE, !accept & issue → EMPTY.
  - ONE, accept & issue → ONE, din loaded into slot0.
  - ONE, neither → ONE.
  - TWO: accept cannot occur because din_rdy=0.
  - TWO, issue → ONE, slot1 moved into slot0.
  - TWO, no issue → TWO.
- Latency: a word accepted into EMPTY appears on fifo_din, with fifo_wr_en active, on the next cycle if the FIFO is not full. Minimum latency is 1 cycle.
- Throughput: 1 word/cycle while fifo_afull=0. While fifo_afull=1 and fifo_full=0, writes are limited to every other cycle.
- Ordering: words leave in strict acceptance order, with no loss or duplication.
- wr_count:
  - Increments by 1 on every cycle in which issue=1.
  - Wraps from 2^CNT_WIDTH-1 to 0.
- idle = (state == EMPTY), registered.
- Reset (asynchronous, any time including mid-burst):
  - state=EMPTY, slot0=0, slot1=0, issue_r=0, wr_count=0.
  - idle=1, din_rdy=1, fifo_din=0.
  - fifo_wr_en inactive immediately: 0 if WRITE_LOW=0, 1 if WRITE_LOW=1.
  - Buffered words are discarded.
- Boundary conditions:
  - fifo_full=1: no issue, regardless of afull or issue_r.
  - Upstream must hold din/din_vld stable while din_rdy=0; the block neither checks nor drops data in this case.
  - Simultaneous accept and issue in ONE: the FIFO receives the old slot0 and the new word becomes slot0 in the same cycle.

Test Plan:
- Reset values: hold reset_wclk_top=1, then release → din_rdy=1, idle=1, wr_count=0, fifo_wr_en=1 (WRITE_LOW=1) and fifo_din=0 throughout.
- Streaming, FIFO never full (WRITE_LOW=0): push 8 words 0x001..0x008 back-to-back → fifo_wr_en high for 8 consecutive cycles starting 1 cycle after the first accept; data in order; wr_count=8; idle=1 afterwards.
- Full stall: hold fifo_full=1 while pushing 3 words → din_rdy drops after the 2nd accept; no writes occur. Release full → 2 writes in order, din_rdy returns, 3rd word written; wr_count=3.
- Almost-full throttle: fifo_afull=1, fifo_full=0, buffer holding 2 words → writes on alternate cycles only; fifo_wr_en is never active on consecutive cycles.
- Reset mid-burst: assert reset with state=TWO → fifo_wr_en inactive in the same cycle; after release, idle=1 and wr_count=0; no stale word is ever written.
- Counter wrap: CNT_WIDTH=4, write 17 words → wr_count reads 1.
